room_thermal_model: RTL and testbench

Synthesizable plant model for the air-conditioning exercise: the room side of the controller's `temperature`/`heating`/`cooling` interface. It consumes the controller's heating and cooling commands and produces the 5-bit room temperature the controller reads. The model advances on a divided update tick and saturates to the 5-bit range. A load handshake lets a bench or top level force step changes in temperature.

---
 rtl/room_thermal_model_pkg.sv | 39 +++
 rtl/room_thermal_model_tick_divider.sv | 38 +++
 rtl/room_thermal_model.sv | 124 ++++++++++++
 tb/tb_room_thermal_model.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/room_thermal_model_pkg.sv
// Shared definitions for the room thermal plant model.
//   TEMP_W / TEMP_MAX : width and ceiling of the room temperature
//   room_mode_t       : plant mode decoded from {cooling, heating}
//   sat_add / sat_sub : saturating arithmetic that never wraps
package room_model_pkg;

    localparam int TEMP_W = 5;
    localparam logic [TEMP_W-1:0] TEMP_MAX = 5'd31;

    typedef enum logic [1:0] {
        DRIFT = 2'b00,
        HEAT  = 2'b01,
        COOL  = 2'b10,
        FAULT = 2'b11
    } room_mode_t;

    // One extra bit of headroom catches the carry so the result clamps at TEMP_MAX.
    function automatic logic [TEMP_W-1:0] sat_add(input logic [TEMP_W-1:0] a,
                                                  input logic [TEMP_W-1:0] b);
        logic [TEMP_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, TEMP_MAX}) begin
            return TEMP_MAX;
        end
        return sum[TEMP_W-1:0];
    endfunction

    // A borrow out of the extra bit means the true result went negative.
    function automatic logic [TEMP_W-1:0] sat_sub(input logic [TEMP_W-1:0] a,
                                                  input logic [TEMP_W-1:0] b);
        logic [TEMP_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[TEMP_W]) begin
            return '0;
        end
        return diff[TEMP_W-1:0];
    endfunction

endpackage

// File: rtl/room_thermal_model_tick_divider.sv
// Update-tick generator for the room model.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : restart the count at 0 (load acceptance)
//   tick       : high while the counter sits at its terminal count;
//                the edge that leaves terminal count is the update edge
module tick_divider #(
    parameter int UPDATE_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (UPDATE_DIV > 2) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(UPDATE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == TERM_CNT)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TERM_CNT);

endmodule

// File: rtl/room_thermal_model.sv
// Room-side plant model for the air-conditioning controller.
//   clk, rst_n              : clock, asynchronous active-low reset
//   heating, cooling        : controller commands, registered into mode_q
//   load_valid/load_temp    : force a new temperature (accepted with load_ready)
//   load_ready              : low for one cycle after each accepted load
//   temperature             : registered 5-bit room temperature
//   update_pulse            : one-cycle strobe aligned with a tick update
//   fault                   : heating and cooling commanded together
// Build option: define ROOM_MODEL_DRIFT_EN to let an idle room drift toward
// AMBIENT; without it an idle room holds its temperature.
//
// mode_q | meaning
// DRIFT  | no command: drift toward AMBIENT (or hold)
// HEAT   | heating: +HEAT_STEP per tick, clamp at 31
// COOL   | cooling: -COOL_STEP per tick, clamp at 0
// FAULT  | both commands: hold temperature, raise fault
module room_thermal_model
    import room_model_pkg::*;
#(
    parameter int INIT_TEMP  = 20,
    parameter int AMBIENT    = 10,
    parameter int UPDATE_DIV = 4,
    parameter int HEAT_STEP  = 5,
    parameter int COOL_STEP  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              heating,
    input  logic              cooling,
    input  logic              load_valid,
    input  logic [TEMP_W-1:0] load_temp,
    output logic              load_ready,
    output logic [TEMP_W-1:0] temperature,
    output logic              update_pulse,
    output logic              fault
);

    localparam logic [TEMP_W-1:0] INIT_T    = TEMP_W'(INIT_TEMP);
    localparam logic [TEMP_W-1:0] AMBIENT_T = TEMP_W'(AMBIENT);
    localparam logic [TEMP_W-1:0] HEAT_T    = TEMP_W'(HEAT_STEP);
    localparam logic [TEMP_W-1:0] COOL_T    = TEMP_W'(COOL_STEP);

    room_mode_t        mode_q, mode_d;
    logic [TEMP_W-1:0] temp_q, temp_d;
    logic              pulse_q, pulse_d;
    logic              ready_q, ready_d;
    logic              load_accept;
    logic              tick;

    assign load_accept = load_valid && ready_q;

    tick_divider #(
        .UPDATE_DIV(UPDATE_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(load_accept),
        .tick (tick)
    );

    always_comb begin
        mode_d = DRIFT;
        case ({cooling, heating})
            2'b01:   mode_d = HEAT;
            2'b10:   mode_d = COOL;
            2'b11:   mode_d = FAULT;
            default: mode_d = DRIFT;
        endcase
    end

    // Tick updates use the mode registered before this edge; a load wins over
    // a coincident tick and suppresses its strobe.
    always_comb begin
        temp_d  = temp_q;
        pulse_d = tick && !load_accept;
        ready_d = !load_accept;
        if (load_accept) begin
            temp_d = load_temp;
        end else if (tick) begin
            case (mode_q)
                HEAT: temp_d = sat_add(temp_q, HEAT_T);
                COOL: temp_d = sat_sub(temp_q, COOL_T);
                DRIFT: begin
`ifdef ROOM_MODEL_DRIFT_EN
                    if (temp_q > AMBIENT_T) begin
                        temp_d = sat_sub(temp_q, 5'd1);
                    end else if (temp_q < AMBIENT_T) begin
                        temp_d = sat_add(temp_q, 5'd1);
                    end
`else
                    temp_d = temp_q;
`endif
                end
                default: temp_d = temp_q;
            endcase
        end
    end

`ifndef ROOM_MODEL_DRIFT_EN
    // Ambient only matters when drift is built in.
    logic unused_ambient;
    assign unused_ambient = ^AMBIENT_T;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= DRIFT;
            temp_q  <= INIT_T;
            pulse_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            mode_q  <= mode_d;
            temp_q  <= temp_d;
            pulse_q <= pulse_d;
            ready_q <= ready_d;
        end
    end

    assign temperature  = temp_q;
    assign update_pulse = pulse_q;
    assign load_ready   = ready_q;
    assign fault        = (mode_q == FAULT);

endmodule

// File: tb/tb_room_thermal_model.sv
module tb_room_thermal_model;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       heating = 1'b0;
    logic       cooling = 1'b0;
    logic       load_valid = 1'b0;
    logic [4:0] load_temp = 5'd0;
    logic       load_ready;
    logic [4:0] temperature;
    logic       update_pulse;
    logic       fault;

    int tests = 0;
    int fails = 0;

    room_thermal_model #(
        .INIT_TEMP (20),
        .AMBIENT   (10),
        .UPDATE_DIV(DIV),
        .HEAT_STEP (5),
        .COOL_STEP (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .heating     (heating),
        .cooling     (cooling),
        .load_valid  (load_valid),
        .load_temp   (load_temp),
        .load_ready  (load_ready),
        .temperature (temperature),
        .update_pulse(update_pulse),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Behavioural room: count edges since reset/load/last update; every DIV-th
    // edge applies the rule chosen by the commands seen one edge earlier.
    int m_temp  = 20;
    int m_edges = 0;
    bit m_pulse = 0;
    bit m_ready = 1;
    bit m_h     = 0;
    bit m_c     = 0;
    bit m_acc;
    bit m_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_temp  = 20;
            m_edges = 0;
            m_pulse = 0;
            m_ready = 1;
            m_h     = 0;
            m_c     = 0;
        end else begin
            m_acc  = load_valid && m_ready;
            m_tick = (m_edges + 1 == DIV);
            if (m_acc) begin
                m_temp  = int'(load_temp);
                m_edges = 0;
            end else if (m_tick) begin
                m_edges = 0;
                if (m_h && !m_c) begin
                    m_temp = (m_temp + 5 > 31) ? 31 : m_temp + 5;
                end else if (m_c && !m_h) begin
                    m_temp = (m_temp - 5 < 0) ? 0 : m_temp - 5;
                end else if (!m_h && !m_c) begin
`ifdef ROOM_MODEL_DRIFT_EN
                    if (m_temp > 10) m_temp = m_temp - 1;
                    else if (m_temp < 10) m_temp = m_temp + 1;
`endif
                end
            end else begin
                m_edges = m_edges + 1;
            end
            m_pulse = m_tick && !m_acc;
            m_ready = !m_acc;
            m_h     = heating;
            m_c     = cooling;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp("model_temperature", int'(temperature), m_temp);
            cmp("model_update_pulse", int'(update_pulse), int'(m_pulse));
            cmp("model_load_ready", int'(load_ready), int'(m_ready));
            cmp("model_fault", int'(fault), int'(m_h && m_c));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input string name);
        bit seen;
        seen = 0;
        for (int n = 0; n < 2 * DIV + 2 && !seen; n++) begin
            @(negedge clk);
            if (update_pulse) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: got no update_pulse expected one within %0d cycles", name, 2 * DIV + 2);
        end
    endtask

`ifdef ROOM_MODEL_DRIFT_EN
    localparam int FIRST_T = 19;
    localparam int SETTLED = 10;
    localparam int T5_NEXT = 25;
    localparam int T6_IDLE = 13;
`else
    localparam int FIRST_T = 20;
    localparam int SETTLED = 20;
    localparam int T5_NEXT = 26;
    localparam int T6_IDLE = 20;
`endif

    initial begin
        #1 rst_n = 1'b0;
        #5;
        cmp("reset_temperature", int'(temperature), 20);
        cmp("reset_update_pulse", int'(update_pulse), 0);
        cmp("reset_fault", int'(fault), 0);
        cmp("reset_load_ready", int'(load_ready), 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // 1: idle drift from 20
        wait_pulse("t1_first_pulse");
        cmp("t1_first_tick_temp", int'(temperature), FIRST_T);
        repeat (60) step();
        cmp("t1_settled_temp", int'(temperature), SETTLED);

        // 2: load 28 and heat -> clamps at 31
        load_valid = 1'b1; load_temp = 5'd28; heating = 1'b1;
        step();
        load_valid = 1'b0;
        cmp("t2_loaded_temp", int'(temperature), 28);
        cmp("t2_ready_low", int'(load_ready), 0);
        wait_pulse("t2_pulse1");
        cmp("t2_heat_sat", int'(temperature), 31);
        wait_pulse("t2_pulse2");
        cmp("t2_heat_hold", int'(temperature), 31);
        cmp("t2_no_fault", int'(fault), 0);

        // 3: load 3 and cool -> clamps at 0
        step();
        load_valid = 1'b1; load_temp = 5'd3; heating = 1'b0; cooling = 1'b1;
        step();
        load_valid = 1'b0;
        wait_pulse("t3_pulse1");
        cmp("t3_cool_sat", int'(temperature), 0);
        wait_pulse("t3_pulse2");
        cmp("t3_cool_hold", int'(temperature), 0);

        // 4: both commands at 15
        step();
        load_valid = 1'b1; load_temp = 5'd15; heating = 1'b1; cooling = 1'b1;
        step();
        load_valid = 1'b0;
        cmp("t4_fault_set", int'(fault), 1);
        repeat (10) step();
        cmp("t4_fault_hold_temp", int'(temperature), 15);
        cmp("t4_fault_still", int'(fault), 1);
        cooling = 1'b0;
        step();
        cmp("t4_fault_clear", int'(fault), 0);
        wait_pulse("t4_pulse");
        cmp("t4_heat_after_fault", int'(temperature), 20);

        // 5: load coincident with a tick edge
        step();
        heating = 1'b0;
        step();
        step();
        load_valid = 1'b1; load_temp = 5'd26;
        step();
        load_valid = 1'b0;
        cmp("t5_loaded_temp", int'(temperature), 26);
        cmp("t5_no_pulse", int'(update_pulse), 0);
        cmp("t5_ready_low", int'(load_ready), 0);
        step();
        cmp("t5_ready_back", int'(load_ready), 1);
        step();
        step();
        cmp("t5_not_yet", int'(update_pulse), 0);
        wait_pulse("t5_pulse");
        cmp("t5_next_tick", int'(temperature), T5_NEXT);

        // 6: asynchronous reset mid-count
        step();
        load_valid = 1'b1; load_temp = 5'd31;
        step();
        load_valid = 1'b0; heating = 1'b1; cooling = 1'b1;
        step();
        step();
        cmp("t6_pre_fault", int'(fault), 1);
        #3 rst_n = 1'b0;
        #1;
        cmp("t6_async_temp", int'(temperature), 20);
        cmp("t6_async_fault", int'(fault), 0);
        cmp("t6_async_ready", int'(load_ready), 1);
        cmp("t6_async_pulse", int'(update_pulse), 0);
        heating = 1'b0; cooling = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) step();
        cmp("t6_idle_temp", int'(temperature), T6_IDLE);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
